// File: rtl/dds_sweep_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : dds_sweep_gen_if
//  Brief    : Control/config and accumulator-drive bundle for dds_sweep_gen.
//  Revision : 1.0 - initial release
// ============================================================================
interface dds_sweep_gen_if #(
    parameter int PHASE_INC_WIDTH = 16,
    parameter int PHASE_ACC_WIDTH = 16,
    parameter int DWELL_WIDTH     = 16
);
    logic                       start_i;
    logic                       stop_i;
    logic                       repeat_i;
    logic                       phase_reset_i;
    logic [PHASE_INC_WIDTH-1:0] f_start_i;
    logic [PHASE_INC_WIDTH-1:0] f_stop_i;
    logic [PHASE_INC_WIDTH-1:0] f_step_i;
    logic [DWELL_WIDTH-1:0]     dwell_i;
    logic [PHASE_INC_WIDTH-1:0] phase_inc_o;
    logic                       phase_inc_ena_o;
    logic [PHASE_ACC_WIDTH-1:0] phase_load_o;
    logic                       phase_load_ena_o;
    logic                       busy_o;
    logic                       done_o;

    modport master (
        output start_i, stop_i, repeat_i, phase_reset_i,
        output f_start_i, f_stop_i, f_step_i, dwell_i,
        input  phase_inc_o, phase_inc_ena_o, phase_load_o, phase_load_ena_o,
        input  busy_o, done_o
    );

    modport slave (
        input  start_i, stop_i, repeat_i, phase_reset_i,
        input  f_start_i, f_stop_i, f_step_i, dwell_i,
        output phase_inc_o, phase_inc_ena_o, phase_load_o, phase_load_ena_o,
        output busy_o, done_o
    );
endinterface
`default_nettype wire

// File: rtl/dds_sweep_gen.sv
`default_nettype none
// ============================================================================
//  Module   : dds_sweep_gen
//  Brief    : Stepped linear frequency-sweep controller driving a DDS phase
//             accumulator's increment and phase-load inputs.
//  Revision : 1.0 - initial release
// ============================================================================
module dds_sweep_gen #(
    parameter int PHASE_INC_WIDTH = 16,
    parameter int PHASE_ACC_WIDTH = 16,
    parameter int DWELL_WIDTH     = 16
) (
    input  wire logic          clk_i,
    input  wire logic          rst_i,
    dds_sweep_gen_if.slave     bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [DWELL_WIDTH-1:0] c_DWELL_ONE = {{(DWELL_WIDTH-1){1'b0}}, 1'b1};

    state_t                     r_state,       w_state_nxt;
    logic                       r_up,          w_up_nxt;
    logic                       r_repeat,      w_repeat_nxt;
    logic                       r_phase_reset, w_phase_reset_nxt;
    logic [PHASE_INC_WIDTH-1:0] r_f_start,     w_f_start_nxt;
    logic [PHASE_INC_WIDTH-1:0] r_f_stop,      w_f_stop_nxt;
    logic [PHASE_INC_WIDTH-1:0] r_f_step,      w_f_step_nxt;
    logic [DWELL_WIDTH-1:0]     r_dwell,       w_dwell_nxt;
    logic [DWELL_WIDTH-1:0]     r_dwell_cnt,   w_dwell_cnt_nxt;
    logic [PHASE_INC_WIDTH-1:0] r_phase_inc,   w_phase_inc_nxt;
    logic                       r_inc_ena,     w_inc_ena_nxt;
    logic                       r_load_ena,    w_load_ena_nxt;
    logic                       r_busy,        w_busy_nxt;
    logic                       r_done,        w_done_nxt;

    logic [PHASE_INC_WIDTH:0]   w_sum;
    logic [PHASE_INC_WIDTH:0]   w_diff;
    logic [PHASE_INC_WIDTH-1:0] w_step_word;
    logic [DWELL_WIDTH-1:0]     w_dwell_eff;
    logic                       w_at_stop;
    logic                       w_dwell_end;

    // One extra bit exposes carry/borrow so the sweep clamps instead of wrapping.
    assign w_sum  = {1'b0, r_phase_inc} + {1'b0, r_f_step};
    assign w_diff = {1'b0, r_phase_inc} - {1'b0, r_f_step};

    always_comb begin
        w_step_word = w_sum[PHASE_INC_WIDTH-1:0];
        if (r_up) begin
            if (w_sum[PHASE_INC_WIDTH] || (w_sum[PHASE_INC_WIDTH-1:0] >= r_f_stop))
                w_step_word = r_f_stop;
            else
                w_step_word = w_sum[PHASE_INC_WIDTH-1:0];
        end else begin
            if (w_diff[PHASE_INC_WIDTH] || (w_diff[PHASE_INC_WIDTH-1:0] <= r_f_stop))
                w_step_word = r_f_stop;
            else
                w_step_word = w_diff[PHASE_INC_WIDTH-1:0];
        end
    end

    assign w_dwell_eff = (bus.dwell_i == '0) ? c_DWELL_ONE : bus.dwell_i;
    assign w_at_stop   = (r_phase_inc == r_f_stop);
    assign w_dwell_end = (r_dwell_cnt == c_DWELL_ONE);

    always_comb begin
        w_state_nxt       = r_state;
        w_up_nxt          = r_up;
        w_repeat_nxt      = r_repeat;
        w_phase_reset_nxt = r_phase_reset;
        w_f_start_nxt     = r_f_start;
        w_f_stop_nxt      = r_f_stop;
        w_f_step_nxt      = r_f_step;
        w_dwell_nxt       = r_dwell;
        w_dwell_cnt_nxt   = r_dwell_cnt;
        w_phase_inc_nxt   = r_phase_inc;
        w_inc_ena_nxt     = r_inc_ena;
        w_busy_nxt        = r_busy;
        w_load_ena_nxt    = 1'b0;
        w_done_nxt        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.start_i && !bus.stop_i) begin
                    w_state_nxt       = ST_RUN;
                    w_up_nxt          = (bus.f_stop_i >= bus.f_start_i);
                    w_repeat_nxt      = bus.repeat_i;
                    w_phase_reset_nxt = bus.phase_reset_i;
                    w_f_start_nxt     = bus.f_start_i;
                    w_f_stop_nxt      = bus.f_stop_i;
                    w_f_step_nxt      = bus.f_step_i;
                    w_dwell_nxt       = w_dwell_eff;
                    w_dwell_cnt_nxt   = w_dwell_eff;
                    w_phase_inc_nxt   = bus.f_start_i;
                    w_inc_ena_nxt     = 1'b1;
                    w_busy_nxt        = 1'b1;
                    w_load_ena_nxt    = bus.phase_reset_i;
                end
            end
            ST_RUN: begin
                // Abort wins over completion arriving in the same cycle.
                if (bus.stop_i) begin
                    w_state_nxt   = ST_IDLE;
                    w_inc_ena_nxt = 1'b0;
                    w_busy_nxt    = 1'b0;
                end else if (w_dwell_end) begin
                    w_dwell_cnt_nxt = r_dwell;
                    if (w_at_stop) begin
                        w_done_nxt = 1'b1;
                        if (r_repeat) begin
                            w_phase_inc_nxt = r_f_start;
                            w_load_ena_nxt  = r_phase_reset;
                        end else begin
                            w_state_nxt   = ST_IDLE;
                            w_inc_ena_nxt = 1'b0;
                            w_busy_nxt    = 1'b0;
                        end
                    end else begin
                        w_phase_inc_nxt = w_step_word;
                    end
                end else begin
                    w_dwell_cnt_nxt = r_dwell_cnt - c_DWELL_ONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= ST_IDLE;
            r_up          <= 1'b0;
            r_repeat      <= 1'b0;
            r_phase_reset <= 1'b0;
            r_f_start     <= '0;
            r_f_stop      <= '0;
            r_f_step      <= '0;
            r_dwell       <= '0;
            r_dwell_cnt   <= '0;
            r_phase_inc   <= '0;
            r_inc_ena     <= 1'b0;
            r_load_ena    <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_up          <= w_up_nxt;
            r_repeat      <= w_repeat_nxt;
            r_phase_reset <= w_phase_reset_nxt;
            r_f_start     <= w_f_start_nxt;
            r_f_stop      <= w_f_stop_nxt;
            r_f_step      <= w_f_step_nxt;
            r_dwell       <= w_dwell_nxt;
            r_dwell_cnt   <= w_dwell_cnt_nxt;
            r_phase_inc   <= w_phase_inc_nxt;
            r_inc_ena     <= w_inc_ena_nxt;
            r_load_ena    <= w_load_ena_nxt;
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
        end
    end

    assign bus.phase_inc_o      = r_phase_inc;
    assign bus.phase_inc_ena_o  = r_inc_ena;
    assign bus.phase_load_o     = {PHASE_ACC_WIDTH{1'b0}};
    assign bus.phase_load_ena_o = r_load_ena;
    assign bus.busy_o           = r_busy;
    assign bus.done_o           = r_done;

endmodule
`default_nettype wire

// File: tb/tb_dds_sweep_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dds_sweep_gen
//  Brief    : Directed self-checking bench for dds_sweep_gen.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dds_sweep_gen;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [19:0] obs;
    logic [19:0] exp_v;

    dds_sweep_gen_if #(.PHASE_INC_WIDTH(16), .PHASE_ACC_WIDTH(16), .DWELL_WIDTH(16)) bus ();

    dds_sweep_gen #(
        .PHASE_INC_WIDTH (16),
        .PHASE_ACC_WIDTH (16),
        .DWELL_WIDTH     (16)
    ) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {phase_inc, ena, busy, done, load_ena}
    assign obs = {bus.phase_inc_o, bus.phase_inc_ena_o, bus.busy_o, bus.done_o, bus.phase_load_ena_o};

    task automatic start_sweep(input logic rep, input logic prst, input logic [15:0] fs,
                               input logic [15:0] fe, input logic [15:0] st, input logic [15:0] dw);
        @(negedge clk);
        bus.repeat_i      = rep;
        bus.phase_reset_i = prst;
        bus.f_start_i     = fs;
        bus.f_stop_i      = fe;
        bus.f_step_i      = st;
        bus.dwell_i       = dw;
        bus.start_i       = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (obs !== 20'h0 || bus.phase_load_o !== 16'h0) begin
            errors++;
            $display("FAIL reset got %h load=%h exp %h load=0000", obs, bus.phase_load_o, 20'h0);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== 20'h0) begin
            errors++;
            $display("FAIL reset_idle got %h exp %h", obs, 20'h0);
        end
    endtask

    task automatic test_up_sweep();
        start_sweep(1'b0, 1'b0, 16'h0100, 16'h0400, 16'h0100, 16'd3);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 1) begin
                // Config changes during RUN must not disturb the sweep.
                bus.start_i  = 1'b0;
                bus.f_start_i = 16'hAAAA;
                bus.f_stop_i  = 16'h0000;
                bus.f_step_i  = 16'h1234;
                bus.dwell_i   = 16'd7;
            end
            if (c <= 12)
                exp_v = {16'(16'h0100 * ((c - 1) / 3 + 1)), 1'b1, 1'b1, 1'b0, 1'b0};
            else if (c == 13)
                exp_v = {16'h0400, 1'b0, 1'b0, 1'b1, 1'b0};
            else
                exp_v = {16'h0400, 1'b0, 1'b0, 1'b0, 1'b0};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL up_sweep cyc %0d got %h exp %h", c, obs, exp_v);
            end
        end
    endtask

    task automatic test_down_clamp();
        start_sweep(1'b0, 1'b0, 16'h1000, 16'h0F00, 16'h0080, 16'd0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) bus.start_i = 1'b0;
            case (c)
                1:       exp_v = {16'h1000, 4'b1100};
                2:       exp_v = {16'h0F80, 4'b1100};
                3:       exp_v = {16'h0F00, 4'b1100};
                4:       exp_v = {16'h0F00, 4'b0010};
                default: exp_v = {16'h0F00, 4'b0000};
            endcase
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL down_clamp cyc %0d got %h exp %h", c, obs, exp_v);
            end
        end
    endtask

    task automatic test_overflow_clamp();
        start_sweep(1'b0, 1'b0, 16'hFF00, 16'hFFF0, 16'h0100, 16'd2);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) bus.start_i = 1'b0;
            if (c <= 2)      exp_v = {16'hFF00, 4'b1100};
            else if (c <= 4) exp_v = {16'hFFF0, 4'b1100};
            else if (c == 5) exp_v = {16'hFFF0, 4'b0010};
            else             exp_v = {16'hFFF0, 4'b0000};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL overflow_clamp cyc %0d got %h exp %h", c, obs, exp_v);
            end
        end
    endtask

    task automatic test_repeat_phase_reset();
        int idx;
        // start_i is left high through RUN; it must be ignored there.
        start_sweep(1'b1, 1'b1, 16'h0010, 16'h0030, 16'h0010, 16'd1);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            idx = (c - 1) % 3;
            if (c <= 9)
                exp_v = {16'(16'h0010 * (idx + 1)), 1'b1, 1'b1, (c == 4 || c == 7), (idx == 0)};
            else
                exp_v = {16'h0030, 4'b0000};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL repeat cyc %0d got %h exp %h", c, obs, exp_v);
            end
            if (c == 9) begin
                // Stop coincides with end of last word: abort must win, no done.
                bus.start_i = 1'b0;
                bus.stop_i  = 1'b1;
            end
            if (c == 10) bus.stop_i = 1'b0;
        end
    endtask

    task automatic test_abort();
        start_sweep(1'b0, 1'b0, 16'h0100, 16'h0400, 16'h0100, 16'd3);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 1) bus.start_i = 1'b0;
            if (c <= 3)      exp_v = {16'h0100, 4'b1100};
            else if (c == 4) exp_v = {16'h0200, 4'b1100};
            else             exp_v = {16'h0200, 4'b0000};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL abort cyc %0d got %h exp %h", c, obs, exp_v);
            end
            if (c == 4) bus.stop_i = 1'b1;
            if (c == 5) bus.stop_i = 1'b0;
        end
    endtask

    task automatic test_start_stop_idle();
        start_sweep(1'b0, 1'b1, 16'h0500, 16'h0600, 16'h0100, 16'd1);
        bus.stop_i = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            exp_v = {16'h0200, 4'b0000};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL start_stop_idle cyc %0d got %h exp %h", c, obs, exp_v);
            end
        end
        bus.start_i = 1'b0;
        bus.stop_i  = 1'b0;
    endtask

    task automatic test_reset_mid_sweep();
        start_sweep(1'b0, 1'b1, 16'h0100, 16'h0400, 16'h0100, 16'd3);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.start_i = 1'b0;
                exp_v = {16'h0100, 4'b1101};
            end else if (c == 2) begin
                exp_v = {16'h0100, 4'b1100};
            end else begin
                exp_v = 20'h0;
            end
            checks++;
            if (obs !== exp_v || bus.phase_load_o !== 16'h0) begin
                errors++;
                $display("FAIL reset_mid cyc %0d got %h exp %h", c, obs, exp_v);
            end
            if (c == 2) rst = 1'b1;
        end
        rst = 1'b0;
        start_sweep(1'b0, 1'b0, 16'h1000, 16'h0F00, 16'h0080, 16'd1);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) bus.start_i = 1'b0;
            case (c)
                1:       exp_v = {16'h1000, 4'b1100};
                2:       exp_v = {16'h0F80, 4'b1100};
                3:       exp_v = {16'h0F00, 4'b1100};
                default: exp_v = {16'h0F00, 4'b0010};
            endcase
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL restart cyc %0d got %h exp %h", c, obs, exp_v);
            end
        end
    endtask

    initial begin
        checks            = 0;
        errors            = 0;
        rst               = 1'b1;
        bus.start_i       = 1'b0;
        bus.stop_i        = 1'b0;
        bus.repeat_i      = 1'b0;
        bus.phase_reset_i = 1'b0;
        bus.f_start_i     = '0;
        bus.f_stop_i      = '0;
        bus.f_step_i      = '0;
        bus.dwell_i       = '0;

        test_reset();
        test_up_sweep();
        test_down_clamp();
        test_overflow_clamp();
        test_repeat_phase_reset();
        test_abort();
        test_start_stop_idle();
        test_reset_mid_sweep();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dds_sweep_gen.md
# dds_sweep_gen

Frequency-sweep (chirp) controller sitting directly upstream of `dds_phase_acc`. It drives the accumulator's phase-increment and phase-load inputs, producing a stepped linear sweep from a start to a stop tuning word:
- each tuning word is held for a programmable dwell time;
- single-shot or continuously repeating;
- optional phase reset at each sweep start.

Its outputs connect one-to-one to `phase_inc_i`, `phase_inc_ena_i`, `phase_load_i` and `phase_load_ena_i` of the accumulator.

## Interface
- PHASE_INC_WIDTH, 16, width of tuning words and step.
- PHASE_ACC_WIDTH, 16, width of phase_load_o.
- DWELL_WIDTH, 16, width of dwell counter/input.
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- start_i  in  1  start request; sampled in IDLE only.
- stop_i  in  1  abort request; sampled in RUN only.
- repeat_i  in  1  0 = single-shot, 1 = restart sweep after last word; latched at start.
- phase_reset_i  in  1  1 = pulse phase load (value 0) at each sweep start; latched at start.
- f_start_i  in  PHASE_INC_WIDTH  first tuning word; latched at start.
- f_stop_i  in  PHASE_INC_WIDTH  last tuning word; latched at start.
- f_step_i  in  PHASE_INC_WIDTH  unsigned step magnitude; latched at start.
- dwell_i  in  DWELL_WIDTH  cycles each word is held; 0 treated as 1; latched at start.
- phase_inc_o  out  PHASE_INC_WIDTH  current tuning word.
- phase_inc_ena_o  out  1  accumulate enable; 1 throughout RUN.
- phase_load_o  out  PHASE_ACC_WIDTH  phase load value; constant 0.
- phase_load_ena_o  out  1  one-cycle phase load pulse.
- busy_o  out  1  1 while in RUN.
- done_o  out  1  one-cycle pulse at sweep completion.

## Operation
- States: IDLE, RUN. All outputs are registered.
- Reset: state IDLE; all outputs 0; config registers 0.
- IDLE → RUN:
  - Trigger: start_i=1 and stop_i=0.
  - Latch config; set direction up if f_stop ≥ f_start, else down.
  - First RUN cycle: phase_inc_o=f_start, phase_inc_ena_o=1, busy_o=1.
  - phase_load_ena_o=1 on that cycle if phase_reset was latched.
- Word hold:
  - Each word is presented for exactly D = max(dwell,1) consecutive cycles.
  - Dwell counter reloads on each new word.
- Step arithmetic:
  - Next word = current ± f_step, computed in PHASE_INC_WIDTH+1 bits.
  - If the result passes or equals f_stop, or wraps, the next word is f_stop (clamp, never wrap).
  - f_step=0: word stays at f_start indefinitely; the sweep never completes, and only stop_i or reset ends it.
- End of last dwell at f_stop:
  - Single-shot: go to IDLE; done_o=1 for one cycle; phase_inc_o holds f_stop; phase_inc_ena_o=0; busy_o=0.
  - Repeat: stay in RUN; next cycle phase_inc_o=f_start; done_o=1 for that cycle; phase_load_ena_o=1 if phase_reset.
- f_start == f_stop: a single word is held D cycles, then completion.
- stop_i in RUN: next cycle IDLE; phase_inc_ena_o=0; phase_inc_o holds last word; no done_o.
- stop_i has priority over start_i and over completion in the same cycle.
- start_i during RUN is ignored.
- Input changes during RUN are ignored until the next start.
- rst_i mid-sweep: next edge forces reset state; no done_o.

## Timing
- start_i high at edge N → phase_inc_o=f_start and busy_o=1 visible after edge N (cycle N+1).
- Word k is valid cycles N+1+k·D … N+k·D+D.
- Single-shot with W words: busy_o high for W·D cycles; done_o in the cycle after the last busy cycle.
- phase_load_ena_o coincides with the first cycle of f_start of each sweep.
- stop_i at edge M → busy_o=0 and phase_inc_ena_o=0 from cycle M+1.

## Test plan
- Up sweep: f_start=0x0100, f_stop=0x0400, f_step=0x0100, dwell=3, repeat=0.
  - → words 0x100,0x200,0x300,0x400, each 3 cycles; busy 12 cycles; done_o one pulse; phase_inc_o stays 0x400 with ena=0.
- Down sweep with clamp: f_start=0x1000, f_stop=0x0F00, f_step=0x0080, dwell=0.
  - → words 0x1000,0x0F80,0x0F00, one cycle each; done_o on the 4th cycle.
- Overflow clamp: f_start=0xFF00, f_stop=0xFFF0, f_step=0x0100, dwell=2.
  - → words 0xFF00,0xFFF0, 2 cycles each; no wrap to 0x0000.
- Repeat with phase_reset=1: 0x10→0x30, step 0x10, dwell=1.
  - → phase_load_ena_o pulses at cycles 1,4,7; done_o at cycles 4,7; busy_o stays 1 throughout.
- Abort and start/stop priority:
  - stop_i asserted during word 0x200 of the first test → ena and busy drop next cycle; phase_inc_o holds 0x200; no done_o.
  - start_i+stop_i together in IDLE → remains IDLE.
- Reset mid-sweep: rst_i pulsed during RUN → all outputs 0 next cycle; a subsequent start_i restarts cleanly from f_start.
